vga_tile_renderer: RTL and testbench

- Pixel source feeding the VGA timing controller's 16-bit RGB565 pixel input.
- Converts the controller's current pixel coordinate into a colour: 80x60 map of 8x8 tiles, 1 bpp tile patterns, 16-entry foreground palette, host-programmable background colour.
- Game logic updates the tile map through a simple write port at any time.

---
 rtl/vga_tile_pkg.sv | 38 +++
 rtl/vga_tile_pattern_rom.sv | 14 +
 rtl/vga_tile_renderer.sv | 177 +++++++++++++++++
 tb/tb_vga_tile_renderer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_tile_pkg.sv
// Shared constants, palette and map entry layout for the VGA tile renderer.
// Tile pattern contents are defined by pattern_row() and read through vga_tile_pattern_rom.
package vga_tile_pkg;

   localparam int unsigned MAP_COLS  = 80;
   localparam int unsigned MAP_ROWS  = 60;
   localparam int unsigned TILE_W    = 8;
   localparam int unsigned MAP_DEPTH = MAP_COLS * MAP_ROWS;
   localparam int unsigned LATENCY   = 4;
   localparam int unsigned SCREEN_W  = MAP_COLS * TILE_W;
   localparam int unsigned SCREEN_H  = MAP_ROWS * TILE_W;

   typedef struct packed {
      logic [5:0] tile;
      logic [3:0] fg;
   } map_entry_t;

   localparam logic [15:0] PALETTE [16] = '{
      16'h0000, 16'h0015, 16'h0540, 16'h0555,
      16'hA800, 16'hA815, 16'hAAA0, 16'hAD55,
      16'h52AA, 16'h52BF, 16'h57EA, 16'h57FF,
      16'hFAAA, 16'hFABF, 16'hFFEA, 16'hFFFF
   };

   // Tile 0 blank, tile 1 solid, tile 2 checker, tile 3 left half; the rest are filler art.
   function automatic logic [7:0] pattern_row(input logic [5:0] tile, input logic [2:0] fy);
      logic [7:0] seed;
      seed = {tile, 2'b00} ^ {fy, 5'b10110};
      case (tile)
         6'd0:    pattern_row = 8'h00;
         6'd1:    pattern_row = 8'hFF;
         6'd2:    pattern_row = fy[0] ? 8'h55 : 8'hAA;
         6'd3:    pattern_row = 8'hF0;
         default: pattern_row = seed ^ {seed[3:0], seed[7:4]};
      endcase
   endfunction

endpackage

// File: rtl/vga_tile_pattern_rom.sv
// 512x8 synchronous tile pattern ROM: address {tile[5:0], fine_y}, MSB is the leftmost pixel.
module vga_tile_pattern_rom
   import vga_tile_pkg::*;
(
   input  logic       clk,
   input  logic [8:0] addr,
   output logic [7:0] data
);

   always_ff @(posedge clk) begin
      data <= pattern_row(addr[8:3], addr[2:0]);
   end

endmodule

// File: rtl/vga_tile_renderer.sv
// Four-stage tile renderer: coordinate -> map RAM -> pattern ROM -> RGB565 pixel.
// Optional macro VGA_TILE_SCROLL_EN adds frame-synchronised toroidal scrolling.
module vga_tile_renderer
   import vga_tile_pkg::*;
(
   input  logic        iCLK,
   input  logic        reset_n,
   input  logic [9:0]  iCurrent_X,
   input  logic [9:0]  iCurrent_Y,
   input  logic        iActive,
   input  logic        iWr_en,
   input  logic [12:0] iWr_addr,
   input  logic [9:0]  iWr_data,
   input  logic        iBg_wr,
   input  logic [15:0] iBg_colour,
`ifdef VGA_TILE_SCROLL_EN
   input  logic        iScroll_wr,
   input  logic [9:0]  iScroll_X,
   input  logic [8:0]  iScroll_Y,
   input  logic        iFrame_start,
`endif
   output logic [15:0] oRGB,
   output logic        oValid
);

   logic        unused_y_msb;
   logic [9:0]  pos_x;
   logic [8:0]  pos_y;

   logic [6:0]  s0_col;
   logic [5:0]  s0_row;
   logic [2:0]  s0_fx;
   logic [2:0]  s0_fy;
   logic        s0_act;
   logic [12:0] map_rd_addr;

   map_entry_t  map_mem [MAP_DEPTH];
   map_entry_t  map_q;
   logic [2:0]  s1_fx;
   logic [2:0]  s1_fy;
   logic        s1_act;

   logic [7:0]  pat_q;
   logic [2:0]  s2_fx;
   logic [3:0]  s2_fg;
   logic        s2_act;

   logic [15:0] bg;
   logic        pix_bit;

   assign unused_y_msb = iCurrent_Y[9];

`ifdef VGA_TILE_SCROLL_EN
   logic [9:0]  pend_x;
   logic [8:0]  pend_y;
   logic [9:0]  live_x;
   logic [8:0]  live_y;
   logic [10:0] sum_x;
   logic [9:0]  sum_y;

   // Live offsets change only at frame start so a frame never tears.
   always_ff @(posedge iCLK or negedge reset_n) begin
      if (!reset_n) begin
         pend_x <= '0;
         pend_y <= '0;
         live_x <= '0;
         live_y <= '0;
      end else begin
         if (iScroll_wr && (iScroll_X < 10'(SCREEN_W)) && (iScroll_Y < 9'(SCREEN_H))) begin
            pend_x <= iScroll_X;
            pend_y <= iScroll_Y;
         end
         if (iFrame_start) begin
            live_x <= pend_x;
            live_y <= pend_y;
         end
      end
   end

   always_comb begin
      sum_x = {1'b0, iCurrent_X} + {1'b0, live_x};
      sum_y = {1'b0, iCurrent_Y[8:0]} + {1'b0, live_y};
      pos_x = (sum_x >= 11'(SCREEN_W)) ? 10'(sum_x - 11'(SCREEN_W)) : sum_x[9:0];
      pos_y = (sum_y >= 10'(SCREEN_H)) ? 9'(sum_y - 10'(SCREEN_H)) : sum_y[8:0];
   end
`else
   assign pos_x = iCurrent_X;
   assign pos_y = iCurrent_Y[8:0];
`endif

   // S0: split coordinate into tile and fine position
   always_ff @(posedge iCLK or negedge reset_n) begin
      if (!reset_n) begin
         s0_col <= '0;
         s0_row <= '0;
         s0_fx  <= '0;
         s0_fy  <= '0;
         s0_act <= 1'b0;
      end else begin
         s0_col <= pos_x[9:3];
         s0_row <= pos_y[8:3];
         s0_fx  <= pos_x[2:0];
         s0_fy  <= pos_y[2:0];
         s0_act <= iActive;
      end
   end

   // row*80 + col as shifts; max 4799 fits 13 bits
   assign map_rd_addr = ({7'd0, s0_row} << 6) + ({7'd0, s0_row} << 4) + {6'd0, s0_col};

   // S1: read-first map RAM, contents survive reset
   always_ff @(posedge iCLK) begin
      if (iWr_en && (iWr_addr < 13'(MAP_DEPTH))) begin
         map_mem[iWr_addr] <= map_entry_t'(iWr_data);
      end
      map_q <= map_mem[map_rd_addr];
   end

   always_ff @(posedge iCLK or negedge reset_n) begin
      if (!reset_n) begin
         s1_fx  <= '0;
         s1_fy  <= '0;
         s1_act <= 1'b0;
      end else begin
         s1_fx  <= s0_fx;
         s1_fy  <= s0_fy;
         s1_act <= s0_act;
      end
   end

   // S2: pattern fetch
   vga_tile_pattern_rom u_pattern_rom (
      .clk  (iCLK),
      .addr ({map_q.tile, s1_fy}),
      .data (pat_q)
   );

   always_ff @(posedge iCLK or negedge reset_n) begin
      if (!reset_n) begin
         s2_fx  <= '0;
         s2_fg  <= '0;
         s2_act <= 1'b0;
      end else begin
         s2_fx  <= s1_fx;
         s2_fg  <= map_q.fg;
         s2_act <= s1_act;
      end
   end

   always_ff @(posedge iCLK or negedge reset_n) begin
      if (!reset_n) begin
         bg <= '0;
      end else if (iBg_wr) begin
         bg <= iBg_colour;
      end
   end

   // S3: pixel select; bg is the pre-load value on the load edge
   assign pix_bit = pat_q[3'd7 - s2_fx];

   always_ff @(posedge iCLK or negedge reset_n) begin
      if (!reset_n) begin
         oRGB   <= '0;
         oValid <= 1'b0;
      end else begin
         oValid <= s2_act;
         if (!s2_act) begin
            oRGB <= '0;
         end else if (pix_bit) begin
            oRGB <= PALETTE[s2_fg];
         end else begin
            oRGB <= bg;
         end
      end
   end

endmodule

// File: tb/tb_vga_tile_renderer.sv
// Self-checking bench for vga_tile_renderer: spec-level pixel model plus literal spot checks.
`timescale 1ns/1ps
module tb_vga_tile_renderer;

   logic        iCLK = 1'b0;
   logic        reset_n;
   logic [9:0]  iCurrent_X;
   logic [9:0]  iCurrent_Y;
   logic        iActive;
   logic        iWr_en;
   logic [12:0] iWr_addr;
   logic [9:0]  iWr_data;
   logic        iBg_wr;
   logic [15:0] iBg_colour;
   logic [15:0] oRGB;
   logic        oValid;
`ifdef VGA_TILE_SCROLL_EN
   logic        iScroll_wr;
   logic [9:0]  iScroll_X;
   logic [8:0]  iScroll_Y;
   logic        iFrame_start;
`endif

   int passed = 0;
   int total  = 0;
   bit done   = 0;

   always #5 iCLK = ~iCLK;

   vga_tile_renderer dut (
      .iCLK       (iCLK),
      .reset_n    (reset_n),
      .iCurrent_X (iCurrent_X),
      .iCurrent_Y (iCurrent_Y),
      .iActive    (iActive),
      .iWr_en     (iWr_en),
      .iWr_addr   (iWr_addr),
      .iWr_data   (iWr_data),
      .iBg_wr     (iBg_wr),
      .iBg_colour (iBg_colour),
`ifdef VGA_TILE_SCROLL_EN
      .iScroll_wr   (iScroll_wr),
      .iScroll_X    (iScroll_X),
      .iScroll_Y    (iScroll_Y),
      .iFrame_start (iFrame_start),
`endif
      .oRGB       (oRGB),
      .oValid     (oValid)
   );

   localparam logic [15:0] PAL [16] = '{
      16'h0000, 16'h0015, 16'h0540, 16'h0555, 16'hA800, 16'hA815, 16'hAAA0, 16'hAD55,
      16'h52AA, 16'h52BF, 16'h57EA, 16'h57FF, 16'hFAAA, 16'hFABF, 16'hFFEA, 16'hFFFF
   };

   function automatic logic [7:0] pat(input int t, input int fy);
      case (t)
         0:       return 8'h00;
         1:       return 8'hFF;
         2:       return (fy % 2 == 1) ? 8'h55 : 8'hAA;
         default: return 8'hF0;
      endcase
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Model state: map contents, background, scroll, and per-cycle pixel records
   logic [9:0]  mmap [4800];
   bit          mknown [4800];
   logic [15:0] mbg = '0;
   int          m_psx = 0, m_psy = 0, m_lsx = 0, m_lsy = 0;
   int          cyc = 0;
   int          r_addr [16];
   int          r_fx [16];
   int          r_fy [16];
   bit          r_act [16];
   bit          r_alive [16];
   logic [9:0]  r_ent [16];
   bit          r_known [16];
   logic [15:0] e_rgb [16];
   bit          e_val [16];
   bit          e_rgbk [16];

   always @(posedge iCLK) begin
      int c, sx, sy, i, t;
      logic [7:0] p;
      cyc++;
      c = cyc - 1;
      if (!reset_n)
         for (int k = 0; k < 4; k++) if (c - k >= 0) r_alive[(c - k) & 15] = 0;
      // coordinate presented in cycle c
      sx = int'(iCurrent_X);
      sy = int'(iCurrent_Y[8:0]);
`ifdef VGA_TILE_SCROLL_EN
      sx = (sx + m_lsx) % 640;
      sy = (sy + m_lsy) % 480;
`endif
      i = c & 15;
      r_addr[i]  = (sy / 8) * 80 + sx / 8;
      r_fx[i]    = sx % 8;
      r_fy[i]    = sy % 8;
      r_act[i]   = iActive;
      r_alive[i] = reset_n;
      // map contents seen by the coordinate from two cycles ago (writes of this edge not yet visible)
      if (c >= 1) begin
         i = (c - 1) & 15;
         r_ent[i]   = mmap[r_addr[i]];
         r_known[i] = mknown[r_addr[i]];
      end
      // output shown in cycle cyc comes from the coordinate four cycles earlier
      if (c >= 3 && reset_n && r_alive[(c - 3) & 15] && r_act[(c - 3) & 15]) begin
         i = (c - 3) & 15;
         t = int'(r_ent[i][9:4]);
         p = pat(t, r_fy[i]);
         e_val[cyc & 15]  = 1;
         e_rgbk[cyc & 15] = r_known[i] && (t <= 3);
         e_rgb[cyc & 15]  = p[7 - r_fx[i]] ? PAL[r_ent[i][3:0]] : mbg;
      end else begin
         e_val[cyc & 15]  = 0;
         e_rgbk[cyc & 15] = 1;
         e_rgb[cyc & 15]  = '0;
      end
      if (iWr_en && iWr_addr < 13'd4800) begin
         mmap[iWr_addr]   = iWr_data;
         mknown[iWr_addr] = 1;
      end
      if (!reset_n) begin
         mbg = '0;
         m_psx = 0; m_psy = 0; m_lsx = 0; m_lsy = 0;
      end else begin
         if (iBg_wr) mbg = iBg_colour;
`ifdef VGA_TILE_SCROLL_EN
         if (iFrame_start) begin
            m_lsx = m_psx;
            m_lsy = m_psy;
         end
         if (iScroll_wr && iScroll_X < 10'd640 && iScroll_Y < 9'd480) begin
            m_psx = int'(iScroll_X);
            m_psy = int'(iScroll_Y);
         end
`endif
      end
   end

   always @(negedge iCLK) begin
      if (!done) begin
         if (!reset_n) begin
            chk("rst_valid", {15'd0, oValid}, 16'h0000);
            chk("rst_rgb", oRGB, 16'h0000);
         end else begin
            chk("pipe_valid", {15'd0, oValid}, {15'd0, e_val[cyc & 15]});
            if (e_rgbk[cyc & 15]) chk("pipe_rgb", oRGB, e_rgb[cyc & 15]);
         end
      end
   end

   task automatic step(input int x, input int y, input bit act);
      iCurrent_X = 10'(x);
      iCurrent_Y = 10'(y);
      iActive    = act;
      @(posedge iCLK);
      #1;
   endtask

   task automatic wr(input int a, input int t, input int fg);
      iWr_en   = 1'b1;
      iWr_addr = 13'(a);
      iWr_data = {6'(t), 4'(fg)};
      step(0, 0, 0);
      iWr_en   = 1'b0;
   endtask

   task automatic px(input string name, input int x, input int y, input logic [15:0] lit);
      step(x, y, 1);
      repeat (3) step(0, 0, 0);
      chk(name, oRGB, lit);
   endtask

   task automatic load_bg(input logic [15:0] colour);
      iBg_wr = 1'b1;
      iBg_colour = colour;
      step(0, 0, 0);
      iBg_wr = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0;
      iCurrent_X = '0; iCurrent_Y = '0; iActive = 1'b0;
      iWr_en = 1'b0; iWr_addr = '0; iWr_data = '0;
      iBg_wr = 1'b0; iBg_colour = '0;
`ifdef VGA_TILE_SCROLL_EN
      iScroll_wr = 1'b0; iScroll_X = '0; iScroll_Y = '0; iFrame_start = 1'b0;
`endif
      repeat (3) @(posedge iCLK);
      #1;
      chk("reset_rgb", oRGB, 16'h0000);
      chk("reset_valid", {15'd0, oValid}, 16'h0000);
      reset_n = 1'b1;

      load_bg(16'h001F);
      wr(0, 1, 2); wr(1, 0, 5); wr(2, 2, 4); wr(3, 3, 15); wr(5, 1, 2); wr(4799, 1, 3);

      for (int x = 0; x < 16; x++) step(x, 0, 1);
      repeat (4) step(0, 0, 0);

      px("tile1_fg2", 3, 0, 16'h0540);
      px("tile0_bg", 8, 0, 16'h001F);
      px("checker_x0y0", 16, 0, 16'hA800);
      px("checker_x1y0", 17, 0, 16'h001F);
      px("checker_x0y1", 16, 1, 16'h001F);
      px("checker_x1y1", 17, 1, 16'hA800);
      px("half_left", 24, 0, 16'hFFFF);
      px("half_right", 28, 0, 16'h001F);
      px("last_entry", 639, 479, 16'h0555);
      px("y_msb_ignored", 0, 512, 16'h0540);

      wr(4800, 1, 4);
      px("wr4800_keeps_4799", 639, 479, 16'h0555);
      px("wr4800_keeps_0", 0, 0, 16'h0540);

      // read and write of entry 5 colliding in the RAM cycle
      px("addr5_before", 41, 0, 16'h0540);
      for (int k = 0; k < 8; k++) begin
         if (k == 3) begin
            iWr_en = 1'b1; iWr_addr = 13'd5; iWr_data = {6'd1, 4'd6};
         end
         step(40, 0, 1);
         iWr_en = 1'b0;
      end
      px("addr5_after", 40, 0, 16'hAAA0);

      for (int k = 0; k < 8; k++) begin
         if (k == 2) begin
            iBg_wr = 1'b1; iBg_colour = 16'h1234;
         end
         step(8 + k, 0, 1);
         iBg_wr = 1'b0;
      end
      px("bg_new", 9, 0, 16'h1234);

      for (int k = 0; k < 6; k++) step(k * 3, 0, 0);
      repeat (4) step(0, 0, 0);
      chk("inactive_valid", {15'd0, oValid}, 16'h0000);
      chk("inactive_rgb", oRGB, 16'h0000);

      for (int k = 0; k < 18; k++) begin
         if (k == 6) begin
            reset_n = 1'b0;
            #1;
            chk("async_rst_valid", {15'd0, oValid}, 16'h0000);
            chk("async_rst_rgb", oRGB, 16'h0000);
         end
         if (k == 8) reset_n = 1'b1;
         step(k, 0, 1);
      end
      repeat (4) step(0, 0, 0);
      px("bg_cleared_by_reset", 8, 0, 16'h0000);
      load_bg(16'h001F);

`ifdef VGA_TILE_SCROLL_EN
      iScroll_wr = 1'b1; iScroll_X = 10'd636; iScroll_Y = 9'd0;
      step(0, 0, 0);
      iScroll_wr = 1'b0;
      px("scroll_pending_only", 10, 0, 16'h001F);
      iFrame_start = 1'b1; step(0, 0, 0); iFrame_start = 1'b0;
      px("scroll_live_x10", 10, 0, 16'h0540);
      px("scroll_live_x9", 9, 0, 16'h0540);
      iScroll_wr = 1'b1; iScroll_X = 10'd640; iScroll_Y = 9'd5;
      step(0, 0, 0);
      iScroll_wr = 1'b0;
      iFrame_start = 1'b1; step(0, 0, 0); iFrame_start = 1'b0;
      px("scroll_bad_write_ignored", 10, 0, 16'h0540);
      iScroll_wr = 1'b1; iScroll_X = 10'd0; iScroll_Y = 9'd479;
      step(0, 0, 0);
      iScroll_wr = 1'b0;
      iFrame_start = 1'b1; step(0, 0, 0); iFrame_start = 1'b0;
      px("scroll_y_wrap", 0, 1, 16'h0540);
      px("scroll_y_wrap_bg", 8, 1, 16'h001F);
`endif

      repeat (6) step(0, 0, 0);
      done = 1;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
